piso_bit_source: RTL and testbench

- Parallel-in/serial-out bit source that sits directly upstream of the 101011 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and drives them out one bit per clock on x_out, which is wired to the detector's x input.
- A one-word hold buffer allows back-to-back words to stream with no idle bit between them, so patterns spanning word boundaries remain detectable.

---
 rtl/pkg_seq_det.sv | 15 +
 rtl/piso_hold_buf.sv | 48 ++++
 rtl/piso_bit_source.sv | 111 +++++++++++
 tb/tb_piso_bit_source.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_seq_det.sv
// Shared definitions for the 101011 sequence-detector slice: FSM states,
// default word width and the detected pattern.
package pkg_seq_det;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Oldest bit is the MSB: the detector fires after seeing 1,0,1,0,1,1.
  localparam logic [5:0] SEQ_PATTERN = 6'b101011;

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry hold register that parks the next word while the current one
// is still being shifted out.
module piso_hold_buf
  import pkg_seq_det::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (push) begin
      data_d = din;
      full_d = 1'b1;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  // NOTE: the data register is deliberately left without reset; full_q
  // qualifies it, so its contents are never observed while stale.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/piso_bit_source.sv
// Parallel-in/serial-out bit source feeding the sequence detector's x input,
// with a one-word hold buffer so consecutive words stream without gaps.
module piso_bit_source
  import pkg_seq_det::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;

  logic             hold_push, hold_pop, hold_full;
  logic [WIDTH-1:0] hold_dout;
  logic             xfer, last_bit, cur_bit;
  logic [WIDTH-1:0] shreg_shifted;

  piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (hold_push),
    .pop   (hold_pop),
    .din   (din),
    .dout  (hold_dout),
    .full  (hold_full)
  );

  // Ready depends on registered state only, never on din_valid.
  assign din_ready = !hold_full;
  assign xfer      = din_valid && din_ready;
  assign last_bit  = (state_q == SHIFT) && (bitcnt_q == LAST_IDX);

  assign cur_bit       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};

  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    hold_push = 1'b0;
    hold_pop  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          shreg_d  = din;
          bitcnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          shreg_d   = shreg_shifted;
          bitcnt_d  = bitcnt_q + 1'b1;
          hold_push = xfer;
        end else if (hold_full) begin
          shreg_d  = hold_dout;
          hold_pop = 1'b1;
          bitcnt_d = '0;
        end else if (xfer) begin
          // Bypass: the word goes straight into the shifter, skipping the hold.
          shreg_d  = din;
          bitcnt_d = '0;
        end else begin
          shreg_d  = '0;
          bitcnt_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  assign x_valid   = (state_q == SHIFT);
  assign x_out     = x_valid ? cur_bit : IDLE_BIT;
  assign word_done = x_valid && (bitcnt_q == LAST_IDX);
  assign busy      = x_valid || hold_full;

endmodule

// File: tb/tb_piso_bit_source.sv
// Self-checking bench: an MSB-first (idle 0) and an LSB-first (idle 1)
// instance share stimulus and are compared every cycle to a word-queue model.
module tb_piso_bit_source;
  import pkg_seq_det::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;

  logic din_ready_a, x_out_a, x_valid_a, word_done_a, busy_a;
  logic din_ready_b, x_out_b, x_valid_b, word_done_b, busy_b;

  int tests = 0;
  int fails = 0;

  piso_bit_source #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready_a),
    .x_out     (x_out_a),
    .x_valid   (x_valid_a),
    .word_done (word_done_a),
    .busy      (busy_a)
  );

  piso_bit_source #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready_b),
    .x_out     (x_out_b),
    .x_valid   (x_valid_b),
    .word_done (word_done_b),
    .busy      (busy_b)
  );

  always #5 clk = ~clk;

  // Model: words accepted but not yet started wait in pend; cur/idx is the
  // word on the wire. A word may be accepted only when nothing is waiting.
  logic [W-1:0] pend[$];
  logic [W-1:0] cur = '0;
  int           idx = 0;
  bit           active = 1'b0;
  bit           last_xfer = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    active    = 1'b0;
    idx       = 0;
    last_xfer = 1'b0;
  endtask

  task automatic model_step();
    bit xfer;
    xfer      = din_valid && (pend.size() == 0);
    last_xfer = xfer;
    if (active) begin
      idx++;
      if (idx == W) active = 1'b0;
    end
    if (xfer) pend.push_back(din);
    if (!active && pend.size() > 0) begin
      cur    = pend.pop_front();
      idx    = 0;
      active = 1'b1;
    end
  endtask

  // Advance one clock; the model consumes the inputs seen at the edge.
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    din_valid = 1'b0;
    model_reset();
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  // Single compare process against the model, every cycle.
  always @(negedge clk) begin
    check("m_xvalid_a", x_valid_a, active);
    check("m_xout_a",   x_out_a,   active ? cur[W-1-idx] : 1'b0);
    check("m_done_a",   word_done_a, active && idx == W-1);
    check("m_busy_a",   busy_a,    active || pend.size() > 0);
    check("m_ready_a",  din_ready_a, pend.size() == 0);
    check("m_xvalid_b", x_valid_b, active);
    check("m_xout_b",   x_out_b,   active ? cur[idx] : 1'b1);
    check("m_done_b",   word_done_b, active && idx == W-1);
    check("m_busy_b",   busy_b,    active || pend.size() > 0);
    check("m_ready_b",  din_ready_b, pend.size() == 0);
  end

  initial begin
    logic [0:7]  seq_ac_msb;
    logic [0:7]  seq_ac_lsb;
    logic [0:7]  seq_55;
    logic [0:7]  seq_2b;
    logic [5:0]  first6;
    logic [23:0] got24;
    int          acc;

    seq_ac_msb = 8'b1010_1100;
    seq_ac_lsb = 8'b0011_0101;
    seq_55     = 8'b0101_0101;
    seq_2b     = 8'b0010_1011;

    model_reset();
    repeat (2) cyc();

    // Single word, both bit orders.
    do_reset();
    din = 8'hAC; din_valid = 1'b1;
    @(negedge clk);
    check("t1_ready_c0", din_ready_a, 1'b1);
    check("t1_valid_c0", x_valid_a, 1'b0);
    cyc(); din_valid = 1'b0;
    first6 = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("t1_xout_msb", x_out_a, seq_ac_msb[k-1]);
      check("t1_xout_lsb", x_out_b, seq_ac_lsb[k-1]);
      check("t1_xvalid",   x_valid_a, 1'b1);
      check("t1_done",     word_done_a, k == 8);
      if (k <= 6) first6 = {first6[4:0], x_out_a};
      cyc();
    end
    @(negedge clk);
    check("t1_pattern",   first6, SEQ_PATTERN);
    check("t1_idle_val",  x_valid_a, 1'b0);
    check("t1_idle_xa",   x_out_a, 1'b0);
    check("t1_idle_xb",   x_out_b, 1'b1);

    // Back-to-back through the hold buffer.
    do_reset();
    din = 8'hAC; din_valid = 1'b1; cyc();
    din_valid = 1'b0; cyc();
    din = 8'h55; din_valid = 1'b1; cyc();
    din_valid = 1'b0;
    for (int k = 3; k <= 16; k++) begin
      @(negedge clk);
      if (k <= 8) check("t2_ready_low", din_ready_a, 1'b0);
      if (k == 9) check("t2_ready_back", din_ready_a, 1'b1);
      if (k >= 9) begin
        check("t2_xout",   x_out_a, seq_55[k-9]);
        check("t2_xvalid", x_valid_a, 1'b1);
      end
      cyc();
    end

    // Bypass at the last bit.
    do_reset();
    din = 8'hAC; din_valid = 1'b1; cyc();
    din_valid = 1'b0;
    repeat (7) cyc();
    din = 8'h2B; din_valid = 1'b1;
    @(negedge clk);
    check("t3_done_c8",  word_done_a, 1'b1);
    check("t3_ready_c8", din_ready_a, 1'b1);
    cyc(); din_valid = 1'b0;
    for (int k = 9; k <= 16; k++) begin
      @(negedge clk);
      check("t3_xout",   x_out_a, seq_2b[k-9]);
      check("t3_xvalid", x_valid_a, 1'b1);
      check("t3_nohold", din_ready_a, 1'b1);
      cyc();
    end
    @(negedge clk);
    check("t3_end_idle", x_valid_a, 1'b0);

    // Reset mid-word with the hold full.
    do_reset();
    din = 8'hAC; din_valid = 1'b1; cyc();
    din_valid = 1'b0; cyc();
    din = 8'h55; din_valid = 1'b1; cyc();
    din_valid = 1'b0;
    @(negedge clk);
    check("t4_hold_full", din_ready_a, 1'b0);
    cyc();
    rst_n = 1'b0; model_reset();
    @(negedge clk);
    check("t4_rst_xout",  x_out_a, 1'b0);
    check("t4_rst_valid", x_valid_a, 1'b0);
    check("t4_rst_busy",  busy_a, 1'b0);
    check("t4_rst_ready", din_ready_a, 1'b1);
    cyc(); rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("t4_no_resid", x_valid_a, 1'b0);
      cyc();
    end

    // LSB-first with 8'h35.
    do_reset();
    din = 8'h35; din_valid = 1'b1; cyc();
    din_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("t5_xout_lsb", x_out_b, seq_ac_msb[k-1]);
      check("t5_done_lsb", word_done_b, k == 8);
      cyc();
    end

    // Three words, third stalled while the hold is full.
    do_reset();
    acc = -1; got24 = '0;
    din = 8'hAC; din_valid = 1'b1; cyc();
    din = 8'h55; din_valid = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c <= 24) begin
        got24 = {got24[22:0], x_out_a};
        check("t6_xvalid", x_valid_a, 1'b1);
      end else begin
        check("t6_end_idle", x_valid_a, 1'b0);
      end
      if (din == 8'h0F && din_valid && din_ready_a && acc < 0) acc = c;
      cyc();
      if (c == 1) begin
        din = 8'h0F; din_valid = 1'b1;
      end else if (acc >= 0) begin
        din_valid = 1'b0;
      end
    end
    check("t6_accept_cyc", acc, 9);
    check("t6_stream", got24, 24'hAC550F);

    // Randomized traffic with occasional resets; the compare process checks it.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!(din_valid && !last_xfer)) begin
        din_valid = ($urandom_range(0, 99) < 45);
        din       = W'($urandom);
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      cyc();
    end
    din_valid = 1'b0;
    repeat (20) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
